reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised successor to the single-read-pair RV32 register file. It provides N combinational read ports, one synchronous write port and a debug read tap, with x0 hardwired to zero. It adds a per-register busy scoreboard, set at issue and cleared at writeback, that the pipeline hazard unit uses to stall. It sits between decode/issue and writeback in the pipelined RV32IM core.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of independent read ports (1..4)

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  asynchronous active-low reset
ADDR_R  in  NUM_READ*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
DATA_R  out  NUM_READ*DATA_WIDTH  read data; port k uses slice [k*DATA_WIDTH +: DATA_WIDTH]
BUSY_R  out  NUM_READ  busy flag of the register addressed on each read port
WRITE_EN  in  1  write strobe
WRITE_ADDR  in  ADDR_WIDTH  write index
WRITE_DATA  in  DATA_WIDTH  write value
ISSUE_EN  in  1  mark ISSUE_ADDR busy (destination of a newly issued instruction)
ISSUE_ADDR  in  ADDR_WIDTH  destination index being issued
DBG_ADDR  in  ADDR_WIDTH  debug tap index
DBG_DATA  out  DATA_WIDTH  debug tap data; raw array content, never bypassed
BUSY_VEC  out  2**ADDR_WIDTH  full scoreboard vector

Behaviour:
- RESET_N low: all registers and all busy bits clear to 0 immediately. Clearing is asynchronous and applies mid-operation. A write presented in the same cycle is discarded. On deassertion, the first update occurs at the next rising CLK.
- Outputs under reset: DATA_R = 0, BUSY_R = 0, DBG_DATA = 0, BUSY_VEC = 0.
- Write: at posedge CLK, if WRITE_EN and WRITE_ADDR != 0, reg[WRITE_ADDR] <= WRITE_DATA. Writes to x0 are silently dropped.
- Read: combinational, zero latency. DATA_R[k] = 0 when ADDR_R[k] == 0, else reg[ADDR_R[k]] (subject to the bypass rule in Optional Feature).
- Duplicate addresses across read ports are legal and return identical data.
- Scoreboard: busy[i] is one flop per register. busy[0] is constant 0.
- At posedge CLK, the next-state of busy[i] is set when ISSUE_EN and ISSUE_ADDR == i and i != 0.
- Otherwise it is cleared when WRITE_EN and WRITE_ADDR == i.
- Otherwise it holds.
- Simultaneous issue and writeback to the same register: set wins, because the issuing instruction is younger.
- BUSY_R[k] = busy[ADDR_R[k]]. The scoreboard value is registered; BUSY_R is not bypassed by a same-cycle writeback.
- Writes to a register whose busy bit is 0 are legal and update the data. No counting: multiple issues to one register collapse into a single busy bit.
- Out-of-range parameters (NUM_READ < 1 or > 4) are rejected by an elaboration-time check.

Optional Feature:
Macro: REG_FILE_BYPASS_EN
- Defined: read ports forward same-cycle write data. If WRITE_EN, WRITE_ADDR != 0 and ADDR_R[k] == WRITE_ADDR, then DATA_R[k] = WRITE_DATA combinationally. In the same case BUSY_R[k] also reads 0 unless ISSUE_EN targets that register in that cycle.
- Undefined: reads return array contents only. New data becomes visible the cycle after the write edge. BUSY_R is the raw registered bit.
- DBG_DATA is unaffected in both cases.

Decomposition:
- Shared package reg_file_pkg holds:
  - Default widths: DATA_WIDTH, ADDR_WIDTH.
  - Constant ZERO_REG = 0.
  - Function for port-slice index arithmetic.
- Sub-module reg_scoreboard owns the busy vector, the set/clear priority logic and its async reset. It exposes BUSY_VEC.
- Top level holds the data array, the read muxes and the bypass logic.

Test Plan:
- Reset then release, write R1 = 0xA5A5A5A5, then read ADDR_R = {R1, R2} next cycle -> DATA_R = {0xA5A5A5A5, 0}, BUSY_R = 0.
- Write x0 = 0xFFFFFFFF, then read x0 on both ports and DBG_ADDR = 0 -> all read 0.
- ISSUE_EN on R5, next cycle read R5 -> BUSY_R = 1. Then write R5 = 0xAAAA5555 -> next cycle BUSY_R = 0, DATA_R = 0xAAAA5555.
- Same cycle: ISSUE_EN R6 and WRITE_EN R6 = 0x12345678 -> after edge BUSY_VEC[6] = 1, reg6 = 0x12345678.
- With REG_FILE_BYPASS_EN: write R7 = 0xDEADBEEF while ADDR_R[0] = 7 -> DATA_R[0] = 0xDEADBEEF before the edge. Without the macro: old value before the edge, new value after it.
- Load R3 = 0x11, set R3 busy, then drop RESET_N between clock edges -> DBG_DATA(R3) = 0 and BUSY_VEC = 0 immediately, with no dependence on CLK.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, the hardwired-zero index and port-slice arithmetic
// for the scoreboarded register file.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_REG       = 0;

    // Low bit of port k's slice in a flattened multi-port bus
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy flags: set on issue, cleared on writeback,
// set wins on a same-cycle collision; x0 is never busy.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0]    ISSUE_ADDR,
    input  logic                     WRITE_EN,
    input  logic [ADDR_WIDTH-1:0]    WRITE_ADDR,
    output logic [2**ADDR_WIDTH-1:0] BUSY_VEC
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: issue (younger) beats writeback, else hold
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == ZERO_REG) begin
                busy_d[i] = 1'b0;
            end else if (ISSUE_EN && (ISSUE_ADDR == addr_t'(i))) begin
                busy_d[i] = 1'b1;
            end else if (WRITE_EN && (WRITE_ADDR == addr_t'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Busy flops, cleared immediately by reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign BUSY_VEC = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// RV32 register file: N async read ports, one write port, debug tap,
// busy scoreboard. Optional write-to-read forwarding: REG_FILE_BYPASS_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = 2
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ADDR_R,
    output logic [NUM_READ*DATA_WIDTH-1:0] DATA_R,
    output logic [NUM_READ-1:0]            BUSY_R,
    input  logic                           WRITE_EN,
    input  logic [ADDR_WIDTH-1:0]          WRITE_ADDR,
    input  logic [DATA_WIDTH-1:0]          WRITE_DATA,
    input  logic                           ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDR,
    input  logic [ADDR_WIDTH-1:0]          DBG_ADDR,
    output logic [DATA_WIDTH-1:0]          DBG_DATA,
    output logic [2**ADDR_WIDTH-1:0]       BUSY_VEC
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("reg_file_sb: NUM_READ must be 1..4");
    end

    data_t regs_q [DEPTH];
    data_t regs_d [DEPTH];
    logic  wr_hit;

    assign wr_hit = WRITE_EN && (WRITE_ADDR != addr_t'(ZERO_REG));

    // Next array contents: at most one non-zero register updated
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[WRITE_ADDR] = WRITE_DATA;
        end
    end

    // Data array, wiped immediately by reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ISSUE_EN   (ISSUE_EN),
        .ISSUE_ADDR (ISSUE_ADDR),
        .WRITE_EN   (WRITE_EN),
        .WRITE_ADDR (WRITE_ADDR),
        .BUSY_VEC   (BUSY_VEC)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        localparam int AL = slice_lo(k, ADDR_WIDTH);
        localparam int DL = slice_lo(k, DATA_WIDTH);

        addr_t ra;
        data_t arr_data;
        logic  arr_busy;

        assign ra       = ADDR_R[AL +: ADDR_WIDTH];
        assign arr_data = (ra == addr_t'(ZERO_REG)) ? '0 : regs_q[ra];
        assign arr_busy = BUSY_VEC[ra];

`ifdef REG_FILE_BYPASS_EN
        // Forwarding is gated by reset so outputs stay zero under reset
        logic fwd;

        assign fwd = RESET_N && wr_hit && (ra == WRITE_ADDR);
        assign DATA_R[DL +: DATA_WIDTH] = fwd ? WRITE_DATA : arr_data;
        assign BUSY_R[k] = fwd ? (ISSUE_EN && (ISSUE_ADDR == ra))
                               : arr_busy;
`else
        assign DATA_R[DL +: DATA_WIDTH] = arr_data;
        assign BUSY_R[k] = arr_busy;
`endif
    end

    // Debug tap always shows raw array contents
    assign DBG_DATA = regs_q[DBG_ADDR];

endmodule
